// File: rtl/cory_delay_arb_pkg.sv
// Shared definitions for cory_delay_arb: state encodings and a ceil-log2 helper.
package cory_delay_arb_pkg;

  localparam logic [1:0] CORY_DARB_IDLE  = 2'd0;
  localparam logic [1:0] CORY_DARB_COUNT = 2'd1;
  localparam logic [1:0] CORY_DARB_DONE  = 2'd2;

  function automatic int unsigned cory_clog2(input int unsigned v);
    int unsigned r;
    int unsigned p;
    r = 0;
    p = 1;
    while (p < v) begin
      p = p << 1;
      r++;
    end
    return r;
  endfunction

endpackage

// File: rtl/cory_rr_arb.sv
// Combinational round-robin pick: first asserted request at or above i_ptr, wrapping modulo NR.
module cory_rr_arb #(
  parameter int unsigned NR = 4,
  parameter int unsigned IW = 2
) (
  input  logic [NR-1:0] i_req,
  input  logic [IW-1:0] i_ptr,
  output logic [NR-1:0] o_gnt,
  output logic [IW-1:0] o_id,
  output logic          o_any
);

  localparam int unsigned SW = IW + 1;

  logic [SW-1:0] w_sum;
  logic [IW-1:0] w_idx;

  // One spare bit holds ptr+j before the modulo-NR fold, so non-power-of-2 NR wraps correctly.
  always_comb begin
    o_gnt = '0;
    o_id  = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_idx = '0;
    for (int unsigned j = 0; j < NR; j++) begin
      w_sum = {1'b0, i_ptr} + SW'(j);
      if (w_sum >= SW'(NR)) w_sum = w_sum - SW'(NR);
      w_idx = w_sum[IW-1:0];
      if (!o_any && i_req[w_idx]) begin
        o_any        = 1'b1;
        o_gnt[w_idx] = 1'b1;
        o_id         = w_idx;
      end
    end
  end

endmodule

// File: rtl/cory_delay_arb.sv
// Round-robin shared delay timer. Optional abort input under CORY_DELAY_ARB_ABORT_EN;
// SIM adds one-hot / counter-stability checks.
module cory_delay_arb
  import cory_delay_arb_pkg::*;
#(
  parameter int unsigned NR = 4,
  parameter int unsigned N  = 8,
  parameter int unsigned IW = cory_clog2(NR)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            i_en,
  input  logic [NR-1:0]   i_a_v,
  input  logic [NR*N-1:0] i_a_preset,
  output logic [NR-1:0]   o_a_r,
  output logic [NR-1:0]   o_z_v,
  output logic [IW-1:0]   o_z_id,
  output logic [N-1:0]    o_z_count,
  output logic            o_busy,
`ifdef CORY_DELAY_ARB_ABORT_EN
  input  logic            i_abort,
`endif
  input  logic [NR-1:0]   i_z_r
);

  logic [1:0]    r_state;
  logic [N-1:0]  r_cnt;
  logic [IW-1:0] r_owner;
  logic [IW-1:0] r_ptr;

  logic [NR-1:0] w_gnt;
  logic [IW-1:0] w_gid;
  logic          w_any;
  logic [N-1:0]  w_preset;
  logic [IW-1:0] w_owner_inc;
  logic          w_abort;

  cory_rr_arb #(
    .NR(NR),
    .IW(IW)
  ) u_rr (
    .i_req (i_a_v),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_id  (w_gid),
    .o_any (w_any)
  );

  assign w_preset    = i_a_preset[32'(w_gid)*N +: N];
  assign w_owner_inc = (r_owner == IW'(NR-1)) ? '0 : r_owner + 1'b1;

`ifdef CORY_DELAY_ARB_ABORT_EN
  assign w_abort = i_abort;
`else
  assign w_abort = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= CORY_DARB_IDLE;
      r_cnt   <= '0;
      r_owner <= '0;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        CORY_DARB_IDLE: begin
          if (w_any) begin
            r_cnt   <= w_preset;
            r_owner <= w_gid;
            r_state <= (w_preset == '0) ? CORY_DARB_DONE : CORY_DARB_COUNT;
          end
        end
        CORY_DARB_COUNT: begin
          // Abort takes priority over the terminal decrement.
          if (w_abort) begin
            r_state <= CORY_DARB_IDLE;
            r_cnt   <= '0;
            r_ptr   <= w_owner_inc;
          end else if (i_en) begin
            r_cnt <= r_cnt - 1'b1;
            if (r_cnt == N'(1)) r_state <= CORY_DARB_DONE;
          end
        end
        CORY_DARB_DONE: begin
          if (i_z_r[r_owner]) begin
            r_state <= CORY_DARB_IDLE;
            r_ptr   <= w_owner_inc;
          end
        end
        default: r_state <= CORY_DARB_IDLE;
      endcase
    end
  end

  // Ready is forced low while reset is held so every output reads zero during reset.
  always_comb begin
    o_a_r = '0;
    o_z_v = '0;
    if (reset_n && (r_state == CORY_DARB_IDLE)) o_a_r = w_gnt;
    if (r_state == CORY_DARB_DONE) o_z_v[r_owner] = 1'b1;
  end

  assign o_z_id    = r_owner;
  assign o_z_count = r_cnt;
  assign o_busy    = (r_state != CORY_DARB_IDLE);

`ifdef SIM
  a_ar_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(o_a_r));
  a_zv_onehot: assert property (@(posedge clk) disable iff (!reset_n) $onehot0(o_z_v));
  a_done_cnt:  assert property (@(posedge clk) disable iff (!reset_n)
                 (r_state == CORY_DARB_DONE) |=> ((r_state != CORY_DARB_DONE) || $stable(r_cnt)));
`endif

endmodule

// File: tb/tb_cory_delay_arb.sv
// Self-checking bench for cory_delay_arb: pick table, directed corner sequences, randomized run vs job-level model.
`timescale 1ns/100ps
module tb_cory_delay_arb;

  localparam int NR = 4;
  localparam int N  = 8;
  localparam int IW = 2;

  logic            clk;
  logic            reset_n;
  logic            i_en;
  logic [NR-1:0]   i_a_v;
  logic [NR*N-1:0] i_a_preset;
  logic [NR-1:0]   o_a_r;
  logic [NR-1:0]   o_z_v;
  logic [IW-1:0]   o_z_id;
  logic [N-1:0]    o_z_count;
  logic            o_busy;
  logic [NR-1:0]   i_z_r;
`ifdef CORY_DELAY_ARB_ABORT_EN
  logic            i_abort;
`endif

  cory_delay_arb #(.NR(NR), .N(N)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .i_en       (i_en),
    .i_a_v      (i_a_v),
    .i_a_preset (i_a_preset),
    .o_a_r      (o_a_r),
    .o_z_v      (o_z_v),
    .o_z_id     (o_z_id),
    .o_z_count  (o_z_count),
    .o_busy     (o_busy),
`ifdef CORY_DELAY_ARB_ABORT_EN
    .i_abort    (i_abort),
`endif
    .i_z_r      (i_z_r)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk;
  int n_fail;

  // Job-level reference: is a job held, has it finished, ticks remaining, owner, next search start.
  bit m_busy;
  bit m_done;
  int m_rem;
  int m_owner;
  int m_ptr;

  logic [NR-1:0] s_ar, s_zv;
  logic [IW-1:0] s_id;
  logic [N-1:0]  s_cnt;
  logic          s_busy;

  typedef struct {
    logic [NR-1:0] av;
    logic [NR-1:0] ar;
  } vec_t;
  vec_t tbl[8];

  int order[$];
  int done_at[$];
  int exp_order[4];

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic int pick(input logic [NR-1:0] v, input int p);
    int k;
    for (int j = 0; j < NR; j++) begin
      k = (p + j) % NR;
      if (v[k]) return k;
    end
    return -1;
  endfunction

  function automatic bit abort_now();
`ifdef CORY_DELAY_ARB_ABORT_EN
    return i_abort;
`else
    return 1'b0;
`endif
  endfunction

  task automatic model_reset();
    m_busy = 0; m_done = 0; m_rem = 0; m_owner = 0; m_ptr = 0;
  endtask

  task automatic model_step();
    int g;
    if (!m_busy) begin
      g = pick(i_a_v, m_ptr);
      if (g >= 0) begin
        m_owner = g;
        m_rem   = int'(i_a_preset[g*N +: N]);
        m_busy  = 1;
        m_done  = (m_rem == 0);
      end
    end else if (!m_done) begin
      if (abort_now()) begin
        m_busy = 0; m_rem = 0; m_ptr = (m_owner + 1) % NR;
      end else if (i_en) begin
        m_rem = m_rem - 1;
        if (m_rem == 0) m_done = 1;
      end
    end else if (i_z_r[m_owner]) begin
      m_busy = 0; m_done = 0; m_ptr = (m_owner + 1) % NR;
    end
  endtask

  task automatic check_all();
    int g;
    logic [NR-1:0] ear, ezv;
    g   = m_busy ? -1 : pick(i_a_v, m_ptr);
    ear = '0;
    if (g >= 0) ear[g] = 1'b1;
    ezv = '0;
    if (m_done) ezv[m_owner] = 1'b1;
    chk("a_r", o_a_r, ear);
    chk("z_v", o_z_v, ezv);
    chk("z_id", o_z_id, m_owner);
    chk("z_count", o_z_count, m_rem);
    chk("busy", o_busy, m_busy);
    s_ar = o_a_r; s_zv = o_z_v; s_id = o_z_id; s_cnt = o_z_count; s_busy = o_busy;
  endtask

  // Called at posedge+1: check mid-cycle, step the model at the edge, drop accepted valids.
  task automatic cyc();
    logic [NR-1:0] acc;
    #3;
    check_all();
    acc = s_ar & i_a_v;
    @(posedge clk);
    if (reset_n) model_step();
    #1;
    i_a_v = i_a_v & ~acc;
  endtask

  task automatic pulse_reset();
    reset_n = 1'b0;
    #1;
    chk("rst_a_r", o_a_r, 0);
    chk("rst_z_v", o_z_v, 0);
    chk("rst_z_id", o_z_id, 0);
    chk("rst_count", o_z_count, 0);
    chk("rst_busy", o_busy, 0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic set_preset(input int k, input int v);
    i_a_preset[k*N +: N] = N'(v);
  endtask

  initial begin
    int k;
    int zv0_seen;
    n_chk = 0; n_fail = 0;
    reset_n = 1'b0; i_en = 1'b0; i_a_v = '0; i_a_preset = '0; i_z_r = '0;
`ifdef CORY_DELAY_ARB_ABORT_EN
    i_abort = 1'b0;
`endif
    model_reset();
    #2;
    chk("reset_a_r", o_a_r, 0);
    chk("reset_z_v", o_z_v, 0);
    chk("reset_z_id", o_z_id, 0);
    chk("reset_count", o_z_count, 0);
    chk("reset_busy", o_busy, 0);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1;

    // Grant pick from ptr=0, applied between clock edges so nothing is accepted.
    tbl[0] = '{4'b0000, 4'b0000};
    tbl[1] = '{4'b0001, 4'b0001};
    tbl[2] = '{4'b1010, 4'b0010};
    tbl[3] = '{4'b1000, 4'b1000};
    tbl[4] = '{4'b1111, 4'b0001};
    tbl[5] = '{4'b0110, 4'b0010};
    tbl[6] = '{4'b1100, 4'b0100};
    tbl[7] = '{4'b0100, 4'b0100};
    for (int i = 0; i < 8; i++) begin
      i_a_v = tbl[i].av;
      #0.4;
      chk("tbl_a_r", o_a_r, tbl[i].ar);
    end
    i_a_v = '0;
    @(posedge clk); #1;

    // A: requester 0, preset 3, done held while ready is low.
    set_preset(0, 3); i_en = 1'b1; i_z_r = '0; i_a_v = 4'b0001;
    cyc();
    chk("A_grant", s_ar, 4'b0001);
    k = 0;
    while (s_zv == 0 && k < 30) begin cyc(); k++; end
    chk("A_latency", k, 4);
    chk("A_z_v", s_zv, 4'b0001);
    chk("A_z_id", s_id, 0);
    chk("A_count", s_cnt, 0);
    repeat (5) begin cyc(); chk("A_hold", s_zv, 4'b0001); end
    i_z_r = 4'b1110;
    cyc();
    chk("A_nonowner_ignored", s_zv, 4'b0001);
    i_z_r = 4'b0001; cyc(); i_z_r = '0; cyc();
    chk("A_idle", s_busy, 0);

    // B: 1 and 3 from ptr=0, then 1 re-posts and 0 joins.
    pulse_reset();
    set_preset(0, 1); set_preset(1, 1); set_preset(3, 1);
    i_a_v = 4'b1010; i_z_r = 4'b1111; i_en = 1'b1;
    order.delete();
    for (int c = 0; c < 60 && order.size() < 4; c++) begin
      cyc();
      if (s_zv != 0) begin
        order.push_back(int'(s_id));
        if (order.size() == 1) i_a_v = i_a_v | 4'b0011;
      end
    end
    exp_order = '{1, 3, 0, 1};
    chk("B_jobs", order.size(), 4);
    for (int i = 0; i < 4; i++)
      if (i < order.size()) chk("B_order", order[i], exp_order[i]);

    // C: preset 0 on requester 2, then all four with preset 0 back to back.
    pulse_reset();
    set_preset(2, 0); i_a_v = 4'b0100; i_z_r = 4'b0100;
    cyc();
    cyc();
    chk("C_z_v_zero_preset", s_zv, 4'b0100);
    pulse_reset();
    for (int i = 0; i < NR; i++) set_preset(i, 0);
    i_a_v = 4'b1111; i_z_r = 4'b1111;
    order.delete(); done_at.delete();
    for (int c = 0; c < 40 && order.size() < 4; c++) begin
      cyc();
      if (s_zv != 0) begin order.push_back(int'(s_id)); done_at.push_back(c); end
    end
    chk("C_jobs", order.size(), 4);
    for (int i = 0; i < order.size(); i++) begin
      chk("C_order", order[i], i);
      if (i > 0) chk("C_gap", done_at[i] - done_at[i-1], 2);
    end

    // D: preset 5 with two stall cycles; others keep posting.
    pulse_reset();
    set_preset(0, 5); for (int i = 1; i < NR; i++) set_preset(i, 2);
    i_a_v = 4'b0001; i_en = 1'b1; i_z_r = '0;
    cyc();
    i_a_v = 4'b1110;
    k = 0;
    while (s_zv == 0 && k < 30) begin
      i_en = !(k == 1 || k == 2);
      cyc();
      k++;
      chk("D_a_r_busy", s_ar, 0);
    end
    i_en = 1'b1;
    chk("D_latency", k, 8);
    chk("D_z_v", s_zv, 4'b0001);
    cyc();
    chk("D_a_r_done", s_ar, 0);

    // E: reset while counting with counter at 2.
    pulse_reset();
    set_preset(0, 4); set_preset(1, 1); set_preset(2, 1);
    i_a_v = 4'b0001; i_en = 1'b1; i_z_r = 4'b1111;
    cyc();
    k = 0;
    while (o_z_count != 2 && k < 10) begin cyc(); k++; end
    chk("E_pre_count", o_z_count, 2);
    i_a_v = 4'b0110;
    pulse_reset();
    zv0_seen = 0;
    order.delete();
    repeat (12) begin
      cyc();
      if (s_zv[0]) zv0_seen++;
      if (s_zv != 0) order.push_back(int'(s_id));
    end
    chk("E_no_stale_done", zv0_seen, 0);
    chk("E_jobs", order.size(), 2);
    if (order.size() > 0) chk("E_first_grant", order[0], 1);

`ifdef CORY_DELAY_ARB_ABORT_EN
    // Abort at the terminal decrement.
    pulse_reset();
    set_preset(1, 4); i_a_v = 4'b0010; i_en = 1'b1; i_z_r = '0;
    cyc();
    k = 0;
    while (o_z_count != 1 && k < 10) begin cyc(); k++; end
    chk("AB_pre_count", o_z_count, 1);
    i_abort = 1'b1;
    cyc();
    i_abort = 1'b0;
    for (int i = 0; i < NR; i++) set_preset(i, 1);
    i_a_v = 4'b1111;
    cyc();
    chk("AB_busy", s_busy, 0);
    chk("AB_z_v", s_zv, 0);
    chk("AB_next_grant", s_ar, 4'b0100);
`endif

    // Randomized traffic against the model.
    pulse_reset();
    i_a_v = '0;
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < NR; i++)
        if (!i_a_v[i] && $urandom_range(0, 3) == 0) begin
          set_preset(i, int'($urandom_range(0, 6)));
          i_a_v[i] = 1'b1;
        end
      i_en  = ($urandom_range(0, 3) != 0);
      i_z_r = NR'($urandom);
`ifdef CORY_DELAY_ARB_ABORT_EN
      i_abort = ($urandom_range(0, 15) == 0);
`endif
      cyc();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
